instr_aligner: RTL and testbench

//   Fetch-side instruction realigner that produces the instruction stream the decompression stage consumes.

---
 rtl/instr_aligner.sv | 155 +++++++++++++++
 tb/tb_instr_aligner.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_aligner.sv
// Realigns word fetches into a 16/32-bit instruction stream; first instr >= 3 cycles after flush on a 0-wait bus.
// Downstream stalls hold the head; fetches stop when fewer than 2 halfword slots would remain. Macro: ALIGNER_RVC_EN.
module instr_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          BUF_HW   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_flush,
  input  logic [31:0] in_flush_pc,
  output logic        out_req,
  output logic [31:0] out_req_addr,
  input  logic        in_req_ready,
  input  logic        in_rsp_valid,
  input  logic [31:0] in_rsp_data,
  input  logic        in_rsp_err,
  output logic        out_valid,
  input  logic        in_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_cif,
  output logic        out_err
);

  localparam int CW = $clog2(BUF_HW + 1);
  localparam int AW = $clog2(BUF_HW);

`ifdef ALIGNER_RVC_EN
  localparam logic RVC_EN = 1'b1;
`else
  localparam logic RVC_EN = 1'b0;
`endif

  logic [15:0]   hw_buf [BUF_HW];
  logic [15:0]   buf_nxt [BUF_HW];
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [31:0]   pc_q;
  logic [31:0]   fetch_ptr;
  logic          drop;
  logic          outstanding;
  logic          discard;
  logic          err_pending;

  logic [1:0]    instr_hw;
  logic [1:0]    pop_hw;
  logic          rsp_take;
  logic          flush_err;
  int            keep_hw;
  int            push_hw;
  int            src;

  logic          flush_pc_unused;
  assign flush_pc_unused = in_flush_pc[0];

  // Halfwords occupied by the head instruction, 0 while it is still incomplete.
  always_comb begin
    instr_hw = 2'd0;
`ifdef ALIGNER_RVC_EN
    if (hw_buf[0][1:0] != 2'b11) begin
      if (count >= CW'(1)) instr_hw = 2'd1;
    end else if (count >= CW'(2)) begin
      instr_hw = 2'd2;
    end
`else
    if (count >= CW'(2)) instr_hw = 2'd2;
`endif
  end

  always_comb begin
    out_valid = 1'b0;
    out_err   = 1'b0;
    out_cif   = 1'b0;
    out_instr = 32'h0;
    if (instr_hw == 2'd1) begin
      out_valid = 1'b1;
      out_cif   = 1'b1;
      out_instr = {16'h0, hw_buf[0]};
    end else if (instr_hw == 2'd2) begin
      out_valid = 1'b1;
      out_instr = {hw_buf[1], hw_buf[0]};
    end else if (err_pending) begin
      out_valid = 1'b1;
      out_err   = 1'b1;
    end
  end

  assign out_pc       = pc_q;
  assign pop_hw       = (out_valid && in_ready && !out_err) ? instr_hw : 2'd0;
  assign rsp_take     = outstanding && in_rsp_valid && !discard && !in_rsp_err;
  assign flush_err    = !RVC_EN && in_flush_pc[1];
  assign out_req_addr = fetch_ptr;
  assign out_req      = !rst && !in_flush && !outstanding && !err_pending &&
                        (count <= CW'(BUF_HW - 2));

  // Shift out popped halfwords, then append the response behind the survivors.
  always_comb begin
    keep_hw   = int'(count) - int'(pop_hw);
    push_hw   = rsp_take ? (drop ? 1 : 2) : 0;
    src       = 0;
    for (int i = 0; i < BUF_HW; i++) begin
      src        = i + int'(pop_hw);
      buf_nxt[i] = 16'h0;
      if (i < keep_hw)
        buf_nxt[i] = hw_buf[src[AW-1:0]];
      else if (i == keep_hw && push_hw >= 1)
        buf_nxt[i] = drop ? in_rsp_data[31:16] : in_rsp_data[15:0];
      else if (i == keep_hw + 1 && push_hw == 2)
        buf_nxt[i] = in_rsp_data[31:16];
    end
    count_nxt = CW'(keep_hw + push_hw);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_HW; i++) hw_buf[i] <= 16'h0;
      count       <= '0;
      pc_q        <= RESET_PC;
      fetch_ptr   <= {RESET_PC[31:2], 2'b00};
      drop        <= RESET_PC[1];
      outstanding <= 1'b0;
      discard     <= 1'b0;
      err_pending <= !RVC_EN && RESET_PC[1];
    end else if (in_flush) begin
      count       <= '0;
      err_pending <= flush_err;
      pc_q        <= {in_flush_pc[31:1], 1'b0};
      fetch_ptr   <= {in_flush_pc[31:2], 2'b00};
      drop        <= in_flush_pc[1];
      // A fetch still in flight must be waited out; its data is thrown away.
      outstanding <= outstanding && !in_rsp_valid;
      discard     <= outstanding && !in_rsp_valid;
    end else begin
      for (int i = 0; i < BUF_HW; i++) hw_buf[i] <= buf_nxt[i];
      count <= count_nxt;
      if (pop_hw != 2'd0)
        pc_q <= pc_q + {29'd0, pop_hw, 1'b0};
      if (outstanding && in_rsp_valid) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
        if (!discard) begin
          if (in_rsp_err)
            err_pending <= 1'b1;
          else
            drop <= 1'b0;
        end
      end
      if (out_req && in_req_ready) begin
        outstanding <= 1'b1;
        fetch_ptr   <= fetch_ptr + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_instr_aligner.sv
// Bench for instr_aligner: randomized bus/downstream timing against a PC-level instruction stream model.
module tb_instr_aligner;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          BUF_HW   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_flush = 1'b0;
  logic [31:0] in_flush_pc = 32'h0;
  logic        out_req;
  logic [31:0] out_req_addr;
  logic        in_req_ready = 1'b0;
  logic        in_rsp_valid = 1'b0;
  logic [31:0] in_rsp_data = 32'h0;
  logic        in_rsp_err = 1'b0;
  logic        out_valid;
  logic        in_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_cif;
  logic        out_err;

  instr_aligner #(.RESET_PC(RESET_PC), .BUF_HW(BUF_HW)) dut (
    .clk(clk), .rst(rst), .in_flush(in_flush), .in_flush_pc(in_flush_pc),
    .out_req(out_req), .out_req_addr(out_req_addr), .in_req_ready(in_req_ready),
    .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data), .in_rsp_err(in_rsp_err),
    .out_valid(out_valid), .in_ready(in_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_cif(out_cif), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] ovr [logic [31:0]];
  bit          fault_en = 1'b0;
  logic [31:0] fault_addr = 32'h0;
  int          ready_pct = 100;
  int          min_delay = 0;
  int          max_delay = 0;
  int          acc_cnt = 0;
  logic [31:0] last_acc_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] x;
    if (ovr.exists(a)) return ovr[a];
    x = a ^ 32'h2545_F491;
    x = x ^ (x >> 16);
    x = x * 32'h045D_9F3B;
    x = x ^ (x >> 16);
    x = x * 32'h045D_9F3B;
    x = x ^ (x >> 16);
    return x;
  endfunction

  function automatic logic [15:0] mem16(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word({a[31:2], 2'b00});
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic bit is_fault(input logic [31:0] a);
    return fault_en && ({a[31:2], 2'b00} == fault_addr);
  endfunction

  // Expected instruction at exp_pc, straight from memory contents and the ISA length rule.
  function automatic void model_head(output logic [31:0] ins, output logic cif,
                                     output bit err, output int len);
    logic [15:0] h0, h1;
    bit          rvc, comp;
`ifdef ALIGNER_RVC_EN
    rvc = 1'b1;
`else
    rvc = 1'b0;
`endif
    h0   = mem16(exp_pc);
    comp = (h0[1:0] != 2'b11);
    err  = is_fault(exp_pc) || (!rvc && exp_pc[1]);
    if (rvc && comp) begin
      ins = {16'h0, h0};
      cif = 1'b1;
      len = 2;
    end else begin
      h1  = mem16(exp_pc + 32'd2);
      ins = {h1, h0};
      cif = 1'b0;
      len = 4;
      if (is_fault(exp_pc + 32'd2)) err = 1'b1;
    end
    if (err) begin
      ins = 32'h0;
      cif = 1'b0;
    end
  endfunction

  // Bus: one request at a time, response after a random number of extra cycles.
  initial begin
    bit          pend_vld;
    int          pend_wait;
    logic [31:0] pend_addr;
    pend_vld  = 1'b0;
    pend_wait = 0;
    pend_addr = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      in_rsp_valid = 1'b0;
      in_rsp_err   = 1'b0;
      in_rsp_data  = 32'h0;
      if (rst) begin
        pend_vld     = 1'b0;
        in_req_ready = 1'b0;
      end else begin
        if (pend_vld) begin
          if (pend_wait == 0) begin
            in_rsp_valid = 1'b1;
            in_rsp_data  = mem_word(pend_addr);
            in_rsp_err   = fault_en && (pend_addr == fault_addr);
            pend_vld     = 1'b0;
          end else begin
            pend_wait--;
          end
        end
        in_req_ready = ($urandom_range(99) < ready_pct);
        if (out_req && in_req_ready) begin
          pend_vld      = 1'b1;
          pend_addr     = out_req_addr;
          pend_wait     = $urandom_range(max_delay, min_delay);
          acc_cnt++;
          last_acc_addr = out_req_addr;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at time %0t, required completion earlier", $time);
    $fatal(1);
  end

  task automatic idle_cycle(input logic rdy);
    @(negedge clk);
    in_flush = 1'b0;
    in_ready = rdy;
    #2;
  endtask

  task automatic do_flush(input logic [31:0] pc);
    @(negedge clk);
    in_flush    = 1'b1;
    in_flush_pc = pc;
    in_ready    = 1'b0;
    #2;
    checks++;
    if (out_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_req: out_req=%b in flush cycle, required 0", out_req);
    end
    exp_pc = {pc[31:1], 1'b0};
  endtask

  task automatic run_stream(input int n, input int rdy_pct, input int budget, output int got);
    logic [31:0] e_instr;
    logic        e_cif;
    bit          e_err, done;
    int          e_len, cyc;
    got  = 0;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      in_flush = 1'b0;
      in_ready = ($urandom_range(99) < rdy_pct);
      #2;
      cyc++;
      if (out_valid === 1'b1) begin
        model_head(e_instr, e_cif, e_err, e_len);
        if (e_err) begin
          checks++;
          if (out_err !== 1'b1 || out_pc !== exp_pc || out_instr !== 32'h0 || out_cif !== 1'b0) begin
            errors++;
            $display("FAIL stream_fault: err=%b pc=%h instr=%h cif=%b, required err=1 pc=%h instr=0 cif=0",
                     out_err, out_pc, out_instr, out_cif, exp_pc);
          end
          done = 1'b1;
        end else if (in_ready) begin
          checks++;
          if (out_err !== 1'b0 || out_pc !== exp_pc || out_instr !== e_instr || out_cif !== e_cif) begin
            errors++;
            $display("FAIL stream_instr: err=%b pc=%h instr=%h cif=%b, required err=0 pc=%h instr=%h cif=%b",
                     out_err, out_pc, out_instr, out_cif, exp_pc, e_instr, e_cif);
            done = 1'b1;
          end
          exp_pc = exp_pc + e_len;
          got++;
          if (got == n) done = 1'b1;
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: %0d of %0d instructions after %0d cycles, required all", got, n, budget);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst      = 1'b1;
    in_flush = 1'b0;
    in_ready = 1'b0;
    #2;
    checks++;
    if (out_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_req: out_req=%b during reset, required 0", out_req);
    end
    idle_cycle(1'b0);
    checks++;
    if (out_valid !== 1'b0 || out_err !== 1'b0 || out_pc !== RESET_PC || out_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b err=%b pc=%h req=%b, required 0 0 %h 0",
               out_valid, out_err, out_pc, out_req, RESET_PC);
    end
    @(negedge clk);
    rst = 1'b0;
    #2;
    checks++;
    if (out_req !== 1'b1 || out_req_addr !== {RESET_PC[31:2], 2'b00}) begin
      errors++;
      $display("FAIL reset_first_req: req=%b addr=%h, required 1 %h", out_req, out_req_addr,
               {RESET_PC[31:2], 2'b00});
    end
    exp_pc = RESET_PC;
  endtask

  task automatic test_stream;
    int got;
    ready_pct = 100; min_delay = 0; max_delay = 0;
    run_stream(3, 100, 60, got);
  endtask

  task automatic test_straddle;
    int got;
    ovr[32'h4] = 32'h0093_4501;
    ovr[32'h8] = 32'h1234_0050;
    ready_pct = 70; min_delay = 0; max_delay = 2;
    do_flush(32'h0000_0004);
    run_stream(3, 100, 100, got);
  endtask

  task automatic test_flush_outstanding;
    int a0, n, got;
    ready_pct = 100; min_delay = 3; max_delay = 3;
    do_flush(32'h0000_0040);
    a0 = acc_cnt; n = 0;
    while (acc_cnt == a0 && n < 20) begin idle_cycle(1'b0); n++; end
    checks++;
    if (acc_cnt == a0) begin
      errors++;
      $display("FAIL fo_first_req: no fetch accepted after %0d cycles, required one", n);
    end
    do_flush(32'h0000_0102);
    min_delay = 0; max_delay = 0;
    a0 = acc_cnt; n = 0;
`ifdef ALIGNER_RVC_EN
    while (acc_cnt == a0 && n < 20) begin idle_cycle(1'b0); n++; end
    checks++;
    if (acc_cnt == a0 || last_acc_addr !== 32'h0000_0100) begin
      errors++;
      $display("FAIL fo_redirect_addr: fetches=%0d addr=%h, required 1 fetch at 00000100", acc_cnt - a0,
               last_acc_addr);
    end
`else
    for (int c = 0; c < 15; c++) idle_cycle(1'b0);
    checks++;
    if (acc_cnt != a0) begin
      errors++;
      $display("FAIL fo_misaligned_req: %0d fetches issued, required 0", acc_cnt - a0);
    end
`endif
    run_stream(6, 100, 100, got);
    // Second redirect lands in the very cycle the zero-wait response returns.
    do_flush(32'h0000_0300);
    a0 = acc_cnt; n = 0;
    while (acc_cnt == a0 && n < 20) begin idle_cycle(1'b0); n++; end
    do_flush(32'h0000_0404);
    run_stream(6, 100, 100, got);
  endtask

  task automatic test_backpressure;
    int          a0, got;
    bit          cap;
    logic [31:0] cap_pc, cap_instr;
    cap = 1'b0; cap_pc = 32'h0; cap_instr = 32'h0;
    ready_pct = 100; min_delay = 0; max_delay = 0;
    do_flush(32'h0000_0200);
    a0 = acc_cnt;
    for (int c = 0; c < 12; c++) begin
      idle_cycle(1'b0);
      if (out_valid === 1'b1) begin
        checks++;
        if (!cap) begin
          cap = 1'b1; cap_pc = out_pc; cap_instr = out_instr;
          if (out_pc !== 32'h0000_0200) begin
            errors++;
            $display("FAIL bp_head_pc: pc=%h, required 00000200", out_pc);
          end
        end else if (out_pc !== cap_pc || out_instr !== cap_instr) begin
          errors++;
          $display("FAIL bp_stable: pc=%h instr=%h, required %h %h", out_pc, out_instr, cap_pc, cap_instr);
        end
      end
    end
    checks++;
    if (acc_cnt - a0 != 2 || last_acc_addr !== 32'h0000_0204) begin
      errors++;
      $display("FAIL bp_fetches: %0d fetches last=%h, required 2 last=00000204", acc_cnt - a0, last_acc_addr);
    end
    run_stream(8, 100, 200, got);
  endtask

  task automatic test_fetch_error;
    int got, want;
    ovr[32'h4] = 32'h0001_0001;
    fault_addr = 32'h0000_0008;
    fault_en   = 1'b1;
    ready_pct = 100; min_delay = 0; max_delay = 2;
    do_flush(32'h0000_0004);
    run_stream(10, 100, 100, got);
`ifdef ALIGNER_RVC_EN
    want = 2;
`else
    want = 1;
`endif
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL ferr_drain: %0d instructions before fault, required %0d", got, want);
    end
    for (int c = 0; c < 5; c++) begin
      idle_cycle(1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_err !== 1'b1 || out_pc !== 32'h0000_0008 || out_instr !== 32'h0) begin
        errors++;
        $display("FAIL ferr_hold: valid=%b err=%b pc=%h instr=%h, required 1 1 00000008 0",
                 out_valid, out_err, out_pc, out_instr);
      end
    end
    fault_en = 1'b0;
  endtask

  task automatic test_misaligned;
    int got;
`ifdef ALIGNER_RVC_EN
    do_flush(32'h0000_0006);
    run_stream(4, 100, 100, got);
`else
    int a0;
    do_flush(32'h0000_0006);
    a0 = acc_cnt;
    for (int c = 0; c < 10; c++) begin
      idle_cycle(1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_err !== 1'b1 || out_pc !== 32'h0000_0006 || out_instr !== 32'h0) begin
        errors++;
        $display("FAIL mis_fault: valid=%b err=%b pc=%h instr=%h, required 1 1 00000006 0",
                 out_valid, out_err, out_pc, out_instr);
      end
    end
    checks++;
    if (acc_cnt != a0) begin
      errors++;
      $display("FAIL mis_no_req: %0d fetches issued, required 0", acc_cnt - a0);
    end
`endif
  endtask

  task automatic test_random;
    int          got;
    logic [31:0] pc;
    for (int it = 0; it < 25; it++) begin
      pc = (it == 7) ? 32'hFFFF_FFF8 : ($urandom & 32'h0003_FFFF);
      ready_pct  = $urandom_range(100, 30);
      min_delay  = 0;
      max_delay  = $urandom_range(3, 0);
      fault_en   = ($urandom_range(3) == 0);
      fault_addr = {pc[31:2], 2'b00} + 32'd4 * $urandom_range(5, 0);
      do_flush(pc);
      run_stream($urandom_range(20, 5), $urandom_range(100, 40), 1500, got);
    end
    fault_en = 1'b0;
  endtask

  task automatic test_reset_midrun;
    int got;
    ready_pct = 80; min_delay = 0; max_delay = 2;
    do_flush(32'h0000_0500);
    run_stream(4, 70, 200, got);
    test_reset();
    run_stream(5, 80, 300, got);
  endtask

  initial begin
    ovr[32'h0] = 32'h0001_4501;
    ovr[32'h4] = 32'h0000_0013;
    test_reset();
    test_stream();
    test_straddle();
    test_flush_outstanding();
    test_backpressure();
    test_fetch_error();
    test_misaligned();
    test_random();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
